// File: rtl/mandlebrot_sched.sv
// Mandelbrot pixel scheduler: circulates up to LATENCY+1 pixels through an external
// squaring datapath. Define MANDLEBROT_SCHED_STATS_EN to enable the retire counter.
`timescale 1ns/1ps
module mandlebrot_sched #(
  parameter int WIDTH    = 8,
  parameter int ID_W     = 8,
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255,
  parameter int LATENCY  = 2*WIDTH+4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_re,
  input  logic [WIDTH-1:0]  in_im,
  input  logic [ID_W-1:0]   in_id,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_id,
  output logic [ITER_W-1:0] out_iter,
  output logic              out_escaped,
  output logic              dp_valid_o,
  output logic [WIDTH-1:0]  dp_re_o,
  output logic [WIDTH-1:0]  dp_im_o,
  input  logic              dp_valid_i,
  input  logic [WIDTH-1:0]  dp_re_i,
  input  logic [WIDTH-1:0]  dp_im_i,
  input  logic              dp_escaped_i,
  output logic [15:0]       stat_retired,
  output logic              idle
);

  localparam int SLOTS = LATENCY + 1;
  localparam int BW    = $clog2(SLOTS + 1);

  typedef struct packed {
    logic [WIDTH-1:0]  c_re;
    logic [WIDTH-1:0]  c_im;
    logic [ID_W-1:0]   id;
    logic [ITER_W-1:0] iter;
    logic              hold;
    logic              esc;
  } tag_t;

  logic [SLOTS-1:0] live_q;
  tag_t             tag_q [SLOTS];
  logic [BW-1:0]    blank_q;

  tag_t              ret;
  logic              ret_live;
  logic              dp_seen;
  logic [ITER_W-1:0] iter_n;
  logic              finish;
  logic              want_retire;
  logic              can_retire;
  logic              retire;
  logic              take_in;

  tag_t              iss_tag;
  logic              iss_live;
  logic [WIDTH-1:0]  iss_re;
  logic [WIDTH-1:0]  iss_im;

  // Slot returning from the datapath this cycle.
  assign ret      = tag_q[SLOTS-1];
  assign ret_live = live_q[SLOTS-1];

  // Returns that were launched before reset are masked until the loop has flushed.
  assign dp_seen = dp_valid_i && (blank_q == '0);

  assign iter_n      = ret.iter + ITER_W'(1);
  assign finish      = ret_live && !ret.hold &&
                       (dp_escaped_i || (iter_n == ITER_W'(MAX_ITER)));
  assign want_retire = ret_live && (ret.hold || finish);
  assign can_retire  = !out_valid || out_ready;
  assign retire      = want_retire && can_retire;

  assign in_ready = !(dp_seen || ret_live) || retire;
  assign take_in  = in_valid && in_ready;

  // NOTE: every variable gets a default before the branches so no latch is inferred.
  always_comb begin
    iss_live = 1'b0;
    iss_tag  = ret;
    iss_re   = dp_re_i + ret.c_re;
    iss_im   = dp_im_i + ret.c_im;
    if (ret_live && !retire) begin
      iss_live = 1'b1;
      if (want_retire) begin
        // Finished but output busy: recirculate with result frozen.
        iss_tag.hold = 1'b1;
        if (!ret.hold) begin
          iss_tag.iter = iter_n;
          iss_tag.esc  = dp_escaped_i;
        end
      end else begin
        iss_tag.iter = iter_n;
      end
    end else if (take_in) begin
      iss_live     = 1'b1;
      iss_tag.c_re = in_re;
      iss_tag.c_im = in_im;
      iss_tag.id   = in_id;
      iss_tag.iter = '0;
      iss_tag.hold = 1'b0;
      iss_tag.esc  = 1'b0;
      iss_re       = in_re;
      iss_im       = in_im;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q     <= '0;
      dp_valid_o <= 1'b0;
      blank_q    <= BW'(SLOTS);
    end else begin
      live_q     <= {live_q[SLOTS-2:0], iss_live};
      dp_valid_o <= iss_live;
      if (blank_q != '0) blank_q <= blank_q - BW'(1);
    end
  end

  // NOTE: slot payloads and datapath words are not reset; they are only meaningful when
  // the matching live bit is set, which is reset.
  always_ff @(posedge clk) begin
    tag_q[0] <= iss_tag;
    for (int k = 1; k < SLOTS; k++) tag_q[k] <= tag_q[k-1];
    dp_re_o <= iss_re;
    dp_im_o <= iss_im;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_id      <= '0;
      out_iter    <= '0;
      out_escaped <= 1'b0;
    end else if (retire) begin
      out_valid   <= 1'b1;
      out_id      <= ret.id;
      out_iter    <= ret.hold ? ret.iter : iter_n;
      out_escaped <= ret.hold ? ret.esc  : dp_escaped_i;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign idle = !(|live_q) && !out_valid;

`ifdef MANDLEBROT_SCHED_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (retire && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_retired = stat_q;
`else
  assign stat_retired = 16'h0000;
`endif

endmodule

// File: tb/tb_mandlebrot_sched.sv
// Randomized bench for mandlebrot_sched with a Q4.4 squaring datapath model and an
// id-keyed reference scoreboard computed directly from the escape-time iteration.
`timescale 1ns/1ps
module tb_mandlebrot_sched;

  localparam int WIDTH    = 8;
  localparam int ID_W     = 8;
  localparam int ITER_W   = 8;
  localparam int MAX_ITER = 16;
  localparam int LATENCY  = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_re;
  logic [WIDTH-1:0]  in_im;
  logic [ID_W-1:0]   in_id;
  logic              out_valid;
  logic              out_ready;
  logic [ID_W-1:0]   out_id;
  logic [ITER_W-1:0] out_iter;
  logic              out_escaped;
  logic              dp_valid_o;
  logic [WIDTH-1:0]  dp_re_o;
  logic [WIDTH-1:0]  dp_im_o;
  logic              dp_valid_i;
  logic [WIDTH-1:0]  dp_re_i;
  logic [WIDTH-1:0]  dp_im_i;
  logic              dp_escaped_i;
  logic [15:0]       stat_retired;
  logic              idle;

  always #5 clk = ~clk;

  mandlebrot_sched #(
    .WIDTH(WIDTH), .ID_W(ID_W), .ITER_W(ITER_W), .MAX_ITER(MAX_ITER), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_iter(out_iter),
    .out_escaped(out_escaped),
    .dp_valid_o(dp_valid_o), .dp_re_o(dp_re_o), .dp_im_o(dp_im_o),
    .dp_valid_i(dp_valid_i), .dp_re_i(dp_re_i), .dp_im_i(dp_im_i), .dp_escaped_i(dp_escaped_i),
    .stat_retired(stat_retired), .idle(idle)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Squaring datapath: Q4.4 z^2, escape when |z|^2 > 4 for the z that was issued.
  typedef struct packed {
    logic       v;
    logic [7:0] re;
    logic [7:0] im;
    logic       esc;
  } dp_t;

  function automatic dp_t dp_step(input logic v, input logic [7:0] re, input logic [7:0] im);
    int  r, i, tr, ti;
    dp_t d;
    r     = int'($signed(re));
    i     = int'($signed(im));
    tr    = (r*r - i*i) >>> 4;
    ti    = (2*r*i) >>> 4;
    d.v   = v;
    d.re  = tr[7:0];
    d.im  = ti[7:0];
    d.esc = (r*r + i*i) > 1024;
    return d;
  endfunction

  // Not reset on purpose: stale returns must survive a DUT reset.
  dp_t dpq [LATENCY];
  always @(posedge clk) begin
    dpq[0] <= dp_step(dp_valid_o, dp_re_o, dp_im_o);
    for (int k = 1; k < LATENCY; k++) dpq[k] <= dpq[k-1];
  end
  assign dp_valid_i   = dpq[LATENCY-1].v;
  assign dp_re_i      = dpq[LATENCY-1].re;
  assign dp_im_i      = dpq[LATENCY-1].im;
  assign dp_escaped_i = dpq[LATENCY-1].esc;

  // Reference: plain escape-time loop z <- z^2 + c.
  function automatic void ref_pix(input logic [7:0] cre, input logic [7:0] cim,
                                  output int it, output logic e);
    logic [7:0] zr, zi;
    dp_t        d;
    zr = cre;
    zi = cim;
    it = 0;
    e  = 1'b0;
    for (int n = 0; n < MAX_ITER; n++) begin
      d  = dp_step(1'b1, zr, zi);
      it = n + 1;
      e  = d.esc;
      if (e) break;
      zr = d.re + cre;
      zi = d.im + cim;
    end
  endfunction

  int   exp_it [int];
  logic exp_e  [int];
  int   pend   [int];
  int   ret_cnt = 0;

  function automatic void expect_pix(input logic [7:0] re, input logic [7:0] im,
                                     input logic [7:0] id);
    int   it;
    logic e;
    ref_pix(re, im, it, e);
    exp_it[int'(id)] = it;
    exp_e[int'(id)]  = e;
    if (pend.exists(int'(id))) pend[int'(id)] = pend[int'(id)] + 1;
    else pend[int'(id)] = 1;
  endfunction

  function automatic int pend_sum();
    int s = 0;
    foreach (pend[k]) s += pend[k];
    return s;
  endfunction

  // Result monitor: every delivered result must be an outstanding id with the model's values.
  always @(negedge clk) begin
    if (!rst_n) begin
      ret_cnt = 0;
    end else if (out_valid && out_ready) begin
      int id;
      int p;
      id = int'(out_id);
      p  = pend.exists(id) ? pend[id] : 0;
      ret_cnt++;
      check("id_outstanding", 32'(p > 0), 32'd1);
      if (p > 0) begin
        pend[id] = p - 1;
        check("out_iter", 32'(out_iter), 32'(exp_it[id]));
        check("out_escaped", 32'(out_escaped), 32'(exp_e[id]));
      end
    end
  end

  // out_ready policy: 0 = stall, 1 = always ready, 2 = random.
  int rdy_mode = 1;
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Called at posedge+1; returns at posedge+1 after the pixel was accepted.
  task automatic send(input logic [7:0] re, input logic [7:0] im, input logic [7:0] id,
                      output int waited);
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    in_id    = id;
    waited   = 0;
    expect_pix(re, im, id);
    @(negedge clk);
    while (!in_ready && waited < 2000) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!idle && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_idle"}, 32'(idle), 32'd1);
    check({tag, "_all_delivered"}, 32'(pend_sum()), 32'd0);
  endtask

  task automatic wait_out(input string tag, input logic [7:0] id, input int it, input logic e);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_id"}, 32'(out_id), 32'(id));
    check({tag, "_iter"}, 32'(out_iter), 32'(it));
    check({tag, "_esc"}, 32'(out_escaped), 32'(e));
  endtask

  function automatic logic [15:0] exp_stat(input int n);
`ifdef MANDLEBROT_SCHED_STATS_EN
    return (n >= 65535) ? 16'hFFFF : 16'(n);
`else
    return (n < 0) ? 16'hFFFF : 16'h0000;
`endif
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [7:0] r, i;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
    in_id    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_out_iter", 32'(out_iter), 32'd0);
    check("rst_out_esc", 32'(out_escaped), 32'd0);
    check("rst_dp_valid", 32'(dp_valid_o), 32'd0);
    check("rst_stat", 32'(stat_retired), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (LATENCY + 2) @(posedge clk);
    #1;

    // Origin never escapes: runs to the iteration limit.
    send(8'd0, 8'd0, 8'd5, w);
    wait_out("origin", 8'd5, MAX_ITER, 1'b0);
    @(posedge clk);
    #1;
    drain("origin");

    // Far point escapes on the first return.
    send(8'd100, 8'd0, 8'd7, w);
    wait_out("far", 8'd7, 1, 1'b1);
    @(posedge clk);
    #1;
    drain("far");

    // Fill every slot back to back, then the next request must stall.
    for (int k = 0; k < LATENCY + 1; k++) begin
      r = 8'(k - 10);
      send(r, 8'd3, 8'(20 + k), w);
      check("burst_accept_wait", 32'(w), 32'd0);
    end
    send(8'd0, 8'd0, 8'd41, w);
    check("full_stall", 32'(w > 0), 32'd1);
    drain("burst");

    // Output stalled for 300 cycles with 5 escaping pixels in flight.
    rdy_mode = 0;
    for (int k = 0; k < 5; k++) send(8'(100 + k), 8'(k), 8'(50 + k), w);
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_first_id", 32'(out_id), 32'd50);
    check("stall_first_iter", 32'(out_iter), 32'd1);
    check("stall_busy", 32'(idle), 32'd0);
    @(posedge clk);
    #1;
    rdy_mode = 1;
    drain("stall");

    // Random traffic with random back-pressure.
    rdy_mode = 2;
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      r = 8'($urandom_range(0, 96)) - 8'd48;
      i = 8'($urandom_range(0, 96)) - 8'd48;
      send(r, i, 8'(100 + k), w);
    end
    rdy_mode = 1;
    drain("random");

    // Reset with 10 pixels in flight.
    for (int k = 0; k < 10; k++) send(8'd0, 8'd0, 8'(200 + k), w);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_idle", 32'(idle), 32'd1);
    check("midrst_stat", 32'(stat_retired), 32'd0);
    pend.delete();
    exp_it.delete();
    exp_e.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < LATENCY + 4; k++) begin
      @(negedge clk);
      check("postrst_in_ready", 32'(in_ready), 32'd1);
      check("postrst_out_valid", 32'(out_valid), 32'd0);
    end
    check("postrst_idle", 32'(idle), 32'd1);
    @(posedge clk);
    #1;

    for (int k = 0; k < 5; k++) send(8'(90 + k), 8'd0, 8'(60 + k), w);
    drain("small");
    check("stat_small", 32'(stat_retired), 32'(exp_stat(ret_cnt)));

    // Bulk retirements to saturate the counter.
    for (int n = 0; n < 70000; n++) send(8'd100, 8'd0, n[7:0], w);
    drain("bulk");
    check("stat_bulk", 32'(stat_retired), 32'(exp_stat(ret_cnt)));
`ifdef MANDLEBROT_SCHED_STATS_EN
    check("stat_saturated", 32'(stat_retired), 32'h0000FFFF);
`else
    check("stat_tied_zero", 32'(stat_retired), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
